// File: rtl/pwm_capture.sv
// pwm_capture -- receive-side decoder for the 4-bit PWM generator.
//
// Samples an asynchronous PWM line and measures its high time and its
// rise-to-rise period in CLK cycles. From these it recovers the duty code,
// flags periods that are not 2^WIDTH long, and reports lines held at one
// level for TIMEOUT cycles.
//
// Parameters:
//   WIDTH   duty-code width; nominal period is 2^WIDTH cycles
//   TIMEOUT cycles without an edge before the line counts as stuck
//           (2^WIDTH < TIMEOUT < 2^(WIDTH+2))
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous, active-high reset
//   PWM_IN     in   PWM waveform, asynchronous to CLK
//   VALID      out  one-cycle strobe; all result outputs update on it
//   DUTY_CODE  out  recovered duty code (WIDTH bits)
//   HIGH_CNT   out  high cycles of the last measured period (WIDTH+2 bits)
//   PERIOD_CNT out  rise-to-rise cycles of the last period (WIDTH+2 bits)
//   PERIOD_ERR out  last period differed from 2^WIDTH
//   STUCK_HI   out  line held high for TIMEOUT cycles (level)
//   STUCK_LO   out  line held low for TIMEOUT cycles (level)
//
// Build option:
//   PWM_CAP_GLITCH_EN  adds a third sample stage; the sampled level only
//                      changes when the two newest synchronized samples
//                      agree, rejecting single-cycle pulses and notches.

module pwm_capture #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWM_IN,
  output logic             VALID,
  output logic [WIDTH-1:0] DUTY_CODE,
  output logic [WIDTH+1:0] HIGH_CNT,
  output logic [WIDTH+1:0] PERIOD_CNT,
  output logic             PERIOD_ERR,
  output logic             STUCK_HI,
  output logic             STUCK_LO
);

  localparam int CW = WIDTH + 2;

  localparam logic [CW-1:0] NOM_PERIOD = CW'(1 << WIDTH);
  localparam logic [CW-1:0] DUTY_MAX   = CW'((1 << WIDTH) - 1);
  localparam logic [CW-1:0] TO_COUNT   = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HIGH    = 3'd1;
  localparam logic [2:0] ST_LOW     = 3'd2;
  localparam logic [2:0] ST_STUCK_H = 3'd3;
  localparam logic [2:0] ST_STUCK_L = 3'd4;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
`ifdef PWM_CAP_GLITCH_EN
  logic             sync3_q, sync3_d;
`endif
  logic             p_q, p_d;
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    hi_lat_q, hi_lat_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] duty_code_q, duty_code_d;
  logic [CW-1:0]    high_cnt_q, high_cnt_d;
  logic [CW-1:0]    period_cnt_q, period_cnt_d;
  logic             period_err_q, period_err_d;
  logic             stuck_hi_q, stuck_hi_d;
  logic             stuck_lo_q, stuck_lo_d;

  logic             s;
  logic             rise, fall;
  logic             timeout;
  logic             go_stuck;
  logic             stuck_next;
  logic [CW-1:0]    hi_m1;

  // Sampled line level. With the filter, a disagreement between the two
  // newest samples keeps the previous level (held in p_q).
`ifdef PWM_CAP_GLITCH_EN
  assign s = (sync2_q == sync3_q) ? sync2_q : p_q;
`else
  assign s = sync2_q;
`endif

  assign rise    = s & ~p_q;
  assign fall    = ~s & p_q;
  // An edge in the same cycle wins over the timeout.
  assign timeout = (cnt_q == TO_COUNT) & ~rise & ~fall;
  assign hi_m1   = hi_lat_q - CNT_ONE;

  always_comb begin
    sync1_d      = PWM_IN;
    sync2_d      = sync1_q;
`ifdef PWM_CAP_GLITCH_EN
    sync3_d      = sync2_q;
`endif
    p_d          = s;
    state_d      = state_q;
    hi_lat_d     = hi_lat_q;
    valid_d      = 1'b0;
    duty_code_d  = duty_code_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    period_err_d = period_err_q;
    stuck_hi_d   = stuck_hi_q;
    stuck_lo_d   = stuck_lo_q;
    go_stuck     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
        end else if (timeout) begin
          go_stuck = 1'b1;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          hi_lat_d = cnt_q;
          state_d  = ST_LOW;
        end else if (timeout) begin
          go_stuck = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise) begin
          valid_d      = 1'b1;
          high_cnt_d   = hi_lat_q;
          period_cnt_d = cnt_q;
          period_err_d = (cnt_q != NOM_PERIOD);
          duty_code_d  = (hi_m1 > DUTY_MAX) ? '1 : hi_m1[WIDTH-1:0];
          state_d      = ST_HIGH;
        end else if (timeout) begin
          go_stuck = 1'b1;
        end
      end
      ST_STUCK_H, ST_STUCK_L: begin
        if (rise) begin
          state_d    = ST_HIGH;
          stuck_hi_d = 1'b0;
          stuck_lo_d = 1'b0;
        end else if (fall) begin
          state_d    = ST_IDLE;
          stuck_hi_d = 1'b0;
          stuck_lo_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A held-high line is also how a full-scale code looks, so STUCK_H
    // reports the all-ones code rather than an error.
    if (go_stuck) begin
      valid_d      = 1'b1;
      high_cnt_d   = '0;
      period_cnt_d = '0;
      if (s) begin
        state_d      = ST_STUCK_H;
        stuck_hi_d   = 1'b1;
        duty_code_d  = '1;
        period_err_d = 1'b0;
      end else begin
        state_d      = ST_STUCK_L;
        stuck_lo_d   = 1'b1;
        duty_code_d  = '0;
        period_err_d = 1'b1;
      end
    end

    // The counter holds while stuck so a single timeout yields a single
    // VALID; it resumes counting (not reloading) when a fall exits to IDLE.
    stuck_next = (state_d == ST_STUCK_H) || (state_d == ST_STUCK_L);
    if (rise) begin
      cnt_d = CNT_ONE;
    end else if (stuck_next || (cnt_q == '1)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
`ifdef PWM_CAP_GLITCH_EN
      sync3_q      <= 1'b0;
`endif
      p_q          <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hi_lat_q     <= '0;
      valid_q      <= 1'b0;
      duty_code_q  <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      period_err_q <= 1'b0;
      stuck_hi_q   <= 1'b0;
      stuck_lo_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
`ifdef PWM_CAP_GLITCH_EN
      sync3_q      <= sync3_d;
`endif
      p_q          <= p_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_lat_q     <= hi_lat_d;
      valid_q      <= valid_d;
      duty_code_q  <= duty_code_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      period_err_q <= period_err_d;
      stuck_hi_q   <= stuck_hi_d;
      stuck_lo_q   <= stuck_lo_d;
    end
  end

  assign VALID      = valid_q;
  assign DUTY_CODE  = duty_code_q;
  assign HIGH_CNT   = high_cnt_q;
  assign PERIOD_CNT = period_cnt_q;
  assign PERIOD_ERR = period_err_q;
  assign STUCK_HI   = stuck_hi_q;
  assign STUCK_LO   = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture -- bench for pwm_capture.
//
// Drives the PWM line one CLK cycle at a time (directed scenarios, then a
// random mix of generator codes, arbitrary high/low segments, glitches and
// mid-run resets). A reference model works from timestamps of the sampled
// line's edges and predicts every output after every clock edge.
// Honours PWM_CAP_GLITCH_EN when the design is built with it.

module tb_pwm_capture;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 32;
  localparam int CW      = WIDTH + 2;
  localparam int NOM     = 1 << WIDTH;
  localparam int CMAX    = (1 << CW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_HIGH = 1;
  localparam int M_LOW  = 2;
  localparam int M_SH   = 3;
  localparam int M_SL   = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             PWM_IN = 1'b0;
  logic             VALID;
  logic [WIDTH-1:0] DUTY_CODE;
  logic [CW-1:0]    HIGH_CNT;
  logic [CW-1:0]    PERIOD_CNT;
  logic             PERIOD_ERR;
  logic             STUCK_HI;
  logic             STUCK_LO;

  pwm_capture #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PWM_IN     (PWM_IN),
    .VALID      (VALID),
    .DUTY_CODE  (DUTY_CODE),
    .HIGH_CNT   (HIGH_CNT),
    .PERIOD_CNT (PERIOD_CNT),
    .PERIOD_ERR (PERIOD_ERR),
    .STUCK_HI   (STUCK_HI),
    .STUCK_LO   (STUCK_LO)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int mode, j, t0, hi_meas;
  bit frozen, s_prev;
  bit hist[$];
  int e_valid, e_duty, e_hi, e_per, e_err, e_sh, e_sl;

  // Observations of the DUT.
  int dut_valids = 0;
  int last_duty, last_hi, last_per, last_err;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pack(input int v, input int d, input int h,
                              input int p, input int e, input int sh,
                              input int sl);
    return (v << 19) | (d << 15) | (h << 9) | (p << 3) | (e << 2) | (sh << 1) | sl;
  endfunction

  function automatic int pack_dut();
    return pack(int'(VALID), int'(DUTY_CODE), int'(HIGH_CNT), int'(PERIOD_CNT),
                int'(PERIOD_ERR), int'(STUCK_HI), int'(STUCK_LO));
  endfunction

  task automatic model_reset();
    mode = M_IDLE; j = 0; t0 = 0; hi_meas = 0;
    frozen = 1'b0; s_prev = 1'b0;
    hist.delete();
    e_valid = 0; e_duty = 0; e_hi = 0; e_per = 0; e_err = 0; e_sh = 0; e_sl = 0;
  endtask

  // Predicts the outputs that follow the clock edge ending cycle j.
  // hist[k] is the line level applied during cycle k since reset release.
  task automatic model_cycle();
    bit sa, s, p, rise, fall, stuck;
    int c, nmode;
    sa = (j >= 2) ? hist[j-2] : 1'b0;
`ifdef PWM_CAP_GLITCH_EN
    begin
      bit sb;
      sb = (j >= 3) ? hist[j-3] : 1'b0;
      s = (sa == sb) ? sa : s_prev;
    end
`else
    s = sa;
`endif
    p = s_prev;
    rise = s && !p;
    fall = !s && p;
    c = frozen ? TIMEOUT : ((j - t0 > CMAX) ? CMAX : j - t0);
    e_valid = 0;
    nmode = mode;
    stuck = (mode == M_IDLE || mode == M_HIGH || mode == M_LOW)
            && !rise && !fall && c == TIMEOUT;
    case (mode)
      M_IDLE: if (rise) nmode = M_HIGH;
      M_HIGH: if (fall) begin hi_meas = c; nmode = M_LOW; end
      M_LOW: if (rise) begin
        e_valid = 1; e_hi = hi_meas; e_per = c;
        e_err = (c != NOM) ? 1 : 0;
        e_duty = (hi_meas - 1 > NOM - 1) ? NOM - 1 : hi_meas - 1;
        nmode = M_HIGH;
      end
      default: begin
        if (rise) begin nmode = M_HIGH; e_sh = 0; e_sl = 0; end
        else if (fall) begin nmode = M_IDLE; e_sh = 0; e_sl = 0; end
      end
    endcase
    if (stuck) begin
      e_valid = 1; e_hi = 0; e_per = 0;
      if (s) begin nmode = M_SH; e_sh = 1; e_duty = NOM - 1; e_err = 0; end
      else begin nmode = M_SL; e_sl = 1; e_duty = 0; e_err = 1; end
    end
    // Count = cycles since the last rise, frozen at TIMEOUT while stuck.
    if (rise) begin
      t0 = j; frozen = 1'b0;
    end else if (nmode == M_SH || nmode == M_SL) begin
      frozen = 1'b1;
    end else if (frozen) begin
      frozen = 1'b0; t0 = j - TIMEOUT;
    end
    mode = nmode;
    s_prev = s;
    j++;
  endtask

  // Entered #1 after a rising edge: compare, drive one cycle, advance.
  task automatic step(input bit v);
    check($sformatf("outs@%0d", j), pack_dut(),
          pack(e_valid, e_duty, e_hi, e_per, e_err, e_sh, e_sl));
    if (VALID) begin
      dut_valids++;
      last_duty = int'(DUTY_CODE); last_hi = int'(HIGH_CNT);
      last_per = int'(PERIOD_CNT); last_err = int'(PERIOD_ERR);
      $display("valid t=%0t duty=%0d high=%0d period=%0d err=%0b stuck_hi=%0b stuck_lo=%0b",
               $time, DUTY_CODE, HIGH_CNT, PERIOD_CNT, PERIOD_ERR, STUCK_HI, STUCK_LO);
    end
    PWM_IN = v;
    hist.push_back(v);
    model_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic seg(input bit v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  // Generator model: code c is high for c+1 of every 2^WIDTH cycles.
  task automatic gen_code(input int c, input int nper);
    for (int k = 0; k < nper; k++)
      for (int i = 0; i < NOM; i++) step((i <= c) ? 1'b1 : 1'b0);
  endtask

  task automatic do_reset(input bit mid);
    RST = 1'b1;
    if (mid) begin
      #1;
      check("rst_async", pack_dut(), 0);
    end
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("rst_hold", pack_dut(), 0);
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    int n0;
    model_reset();
    do_reset(1'b0);

    // Code 5, three periods: two measurements.
    n0 = dut_valids;
    gen_code(5, 3); seg(0, 6);
    check("code5_nvalid", dut_valids - n0, 2);
    check("code5_hi", last_hi, 6);
    check("code5_per", last_per, 16);
    check("code5_duty", last_duty, 5);
    check("code5_err", last_err, 0);

    // Code 0: one-cycle pulses.
    do_reset(1'b0);
    gen_code(0, 3); seg(0, 6);
`ifdef PWM_CAP_GLITCH_EN
    check("code0_stuck_lo", int'(STUCK_LO), 1);
`else
    check("code0_hi", last_hi, 1);
    check("code0_per", last_per, 16);
    check("code0_duty", last_duty, 0);
`endif

    // Code 15: constant high, then released low.
    do_reset(1'b0);
    n0 = dut_valids;
    seg(1, 48);
    check("code15_nvalid", dut_valids - n0, 1);
    check("code15_stuck_hi", int'(STUCK_HI), 1);
    check("code15_duty", int'(DUTY_CODE), 15);
    check("code15_hi", int'(HIGH_CNT), 0);
    seg(0, 5);
    check("code15_clear", int'(STUCK_HI), 0);

    // Line held low from reset.
    do_reset(1'b0);
    n0 = dut_valids;
    seg(0, 40);
    check("low_nvalid", dut_valids - n0, 1);
    check("low_stuck_lo", int'(STUCK_LO), 1);
    check("low_duty", int'(DUTY_CODE), 0);
    check("low_err", int'(PERIOD_ERR), 1);

    // High 4 / period 20.
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) begin seg(1, 4); seg(0, 16); end
    seg(0, 6);
    check("p20_hi", last_hi, 4);
    check("p20_per", last_per, 20);
    check("p20_duty", last_duty, 3);
    check("p20_err", last_err, 1);

    // Reset while the line is high, then recovery.
    do_reset(1'b0);
    gen_code(5, 2); seg(1, 3);
    do_reset(1'b1);
    seg(1, 3); seg(0, 10);
    gen_code(5, 3); seg(0, 6);
    check("rst_rec_hi", last_hi, 6);
    check("rst_rec_per", last_per, 16);
    check("rst_rec_duty", last_duty, 5);
    check("rst_rec_err", last_err, 0);

    // Random mix.
    do_reset(1'b0);
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0, 1: gen_code($urandom_range(0, 15), $urandom_range(1, 4));
        2: begin
          seg(1, $urandom_range(1, 40));
          seg(0, $urandom_range(1, 40));
        end
        3: for (int g = 0; g < 6; g++) seg(g[0], $urandom_range(1, 3));
        default: do_reset(1'b1);
      endcase
    end
    seg(0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
